// File: rtl/vga_sram_arbiter_pkg.sv
// vga_sram_pkg: shared types and defaults for the VGA/CPU SRAM arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which client owns (or last owned) the SRAM
//   req_t       : generic request payload at the default widths
package vga_sram_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {IDLE, ACCESS} arb_state_t;

    typedef enum logic {GNT_VGA, GNT_CPU} grant_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [3:0]            byte_sel;
        logic                  we;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/vga_sram_arbiter_req_slot.sv
// req_slot: one-entry request register for a single arbiter client.
//   clk, rst_i   : clock, synchronous active-high reset
//   req_i        : request strobe, captured only while the slot is empty
//   req_data_i   : payload latched on capture
//   clr_i        : empties the slot (access finished or aborted)
//   full_o       : slot holds a request (doubles as the client's busy flag)
//   data_o       : latched payload
module req_slot
    import vga_sram_pkg::*;
#(
    parameter type payload_t = req_t
) (
    input  logic     clk,
    input  logic     rst_i,
    input  logic     req_i,
    input  payload_t req_data_i,
    input  logic     clr_i,
    output logic     full_o,
    output payload_t data_o
);

    logic     full_q, full_d;
    payload_t data_q, data_d;

    // Capture and clear can never coincide: capture needs an empty slot,
    // clear is only issued for the slot currently in service.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (req_i && !full_q) begin
            full_d = 1'b1;
            data_d = req_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter: shares one SRAM between the VGA pixel reader and the
// CPU data port. One pending request per client; VGA wins ties during
// active display, otherwise ties alternate. One access at a time with an
// ack handshake and a timeout abort.
//   clk, rst                       : clock, synchronous active-high reset
//   vga_req/word_addr/byte_sel     : VGA read request
//   vga_state                      : 1 = active display (VGA priority)
//   vga_rdata, vga_busy            : VGA read data / request outstanding
//   cpu_req/we/addr/wdata/byte_sel : CPU request
//   cpu_rdata, cpu_busy            : CPU read data / request outstanding
//   mem_*                          : SRAM access port (en/we/addr/wdata/byte_sel out, rdata/ack in)
//   timeout_err                    : one-cycle pulse on an aborted access
module vga_sram_arbiter
    import vga_sram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_word_addr,
    input  logic [3:0]        vga_byte_sel,
    input  logic              vga_state,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_busy,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_byte_sel,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // VGA only reads, so its slot carries no write fields.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        byte_sel;
    } vga_slot_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        byte_sel;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } cpu_slot_t;

    vga_slot_t vga_slot;
    cpu_slot_t cpu_slot;
    logic      vga_full, cpu_full;
    logic      vga_clr, cpu_clr;

    req_slot #(.payload_t(vga_slot_t)) u_vga_slot (
        .clk        (clk),
        .rst_i      (rst),
        .req_i      (vga_req),
        .req_data_i ('{addr: vga_word_addr, byte_sel: vga_byte_sel}),
        .clr_i      (vga_clr),
        .full_o     (vga_full),
        .data_o     (vga_slot)
    );

    req_slot #(.payload_t(cpu_slot_t)) u_cpu_slot (
        .clk        (clk),
        .rst_i      (rst),
        .req_i      (cpu_req),
        .req_data_i ('{addr: cpu_addr, byte_sel: cpu_byte_sel, we: cpu_we, wdata: cpu_wdata}),
        .clr_i      (cpu_clr),
        .full_o     (cpu_full),
        .data_o     (cpu_slot)
    );

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;      // client owning the current access
    grant_t            rr_q, rr_d;        // client preferred on the next tie
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_byte_sel_q, mem_byte_sel_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              terr_q, terr_d;
    logic              pick_vga;

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;
        mem_en_d       = mem_en_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_byte_sel_d = mem_byte_sel_q;
        vga_rdata_d    = vga_rdata_q;
        cpu_rdata_d    = cpu_rdata_q;
        terr_d         = 1'b0;
        vga_clr        = 1'b0;
        cpu_clr        = 1'b0;
        pick_vga       = 1'b0;
        case (state_q)
            IDLE: begin
                if (vga_full || cpu_full) begin
                    pick_vga = vga_full && (!cpu_full || vga_state || (rr_q == GNT_VGA));
                    if (pick_vga) begin
                        gnt_d          = GNT_VGA;
                        rr_d           = GNT_CPU;
                        mem_we_d       = 1'b0;
                        mem_addr_d     = vga_slot.addr;
                        mem_byte_sel_d = vga_slot.byte_sel;
                        mem_wdata_d    = '0;
                    end else begin
                        gnt_d          = GNT_CPU;
                        rr_d           = GNT_VGA;
                        mem_we_d       = cpu_slot.we;
                        mem_addr_d     = cpu_slot.addr;
                        mem_byte_sel_d = cpu_slot.byte_sel;
                        mem_wdata_d    = cpu_slot.wdata;
                    end
                    mem_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    mem_en_d = 1'b0;
                    state_d  = IDLE;
                    terr_d   = !mem_ack;
                    if (gnt_q == GNT_VGA) begin
                        vga_clr     = 1'b1;
                        vga_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        cpu_clr = 1'b1;
                        if (!mem_ack) begin
                            cpu_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_q          <= GNT_VGA;
            rr_q           <= GNT_VGA;
            cnt_q          <= '0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_byte_sel_q <= '0;
            vga_rdata_q    <= '0;
            cpu_rdata_q    <= '0;
            terr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rr_q           <= rr_d;
            cnt_q          <= cnt_d;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_byte_sel_q <= mem_byte_sel_d;
            vga_rdata_q    <= vga_rdata_d;
            cpu_rdata_q    <= cpu_rdata_d;
            terr_q         <= terr_d;
        end
    end

    assign vga_busy     = vga_full;
    assign cpu_busy     = cpu_full;
    assign vga_rdata    = vga_rdata_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_byte_sel = mem_byte_sel_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Testbench for vga_sram_arbiter: directed scenarios followed by a random
// phase checked against a transaction-level model of the arbiter.
module tb_vga_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, vga_state, vga_busy;
    logic [AW-1:0] vga_word_addr;
    logic [3:0]    vga_byte_sel;
    logic [DW-1:0] vga_rdata;
    logic          cpu_req, cpu_we, cpu_busy;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic [3:0]    cpu_byte_sel;
    logic          mem_en, mem_we, mem_ack, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_byte_sel;

    always #5 clk = ~clk;

    vga_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .vga_req       (vga_req),
        .vga_word_addr (vga_word_addr),
        .vga_byte_sel  (vga_byte_sel),
        .vga_state     (vga_state),
        .vga_rdata     (vga_rdata),
        .vga_busy      (vga_busy),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byte_sel  (cpu_byte_sel),
        .cpu_rdata     (cpu_rdata),
        .cpu_busy      (cpu_busy),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_byte_sel  (mem_byte_sel),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .timeout_err   (timeout_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_with(input logic [DW-1:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
    endtask

    // Reference model: one pending request per client, one access in flight.
    typedef struct {
        bit          v;
        logic [31:0] addr;
        logic [3:0]  bs;
        bit          we;
        logic [31:0] wd;
    } mreq_t;

    mreq_t       pend[2];
    bit          act;
    int          who;
    int          age;
    int          last;
    bit          terr;
    logic [31:0] rd[2];
    logic [31:0] sram[16];

    int  n_hi;
    int  done;
    bit  cap_v, cap_c;
    bit  stall;

    initial begin
        rst = 1'b1; vga_req = 1'b1; cpu_req = 1'b1; vga_state = 1'b0;
        vga_word_addr = 32'h44; vga_byte_sel = 4'hF;
        cpu_we = 1'b0; cpu_addr = 32'h55; cpu_wdata = 32'h0; cpu_byte_sel = 4'hF;
        mem_ack = 1'b0; mem_rdata = '0;

        // ---------------- reset with requests held high
        step(); step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_bs", mem_byte_sel, 0);
        chk("rst_vga_busy", vga_busy, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_vga_rdata", vga_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_terr", timeout_err, 0);
        rst = 1'b0; vga_req = 1'b0; cpu_req = 1'b0;
        step();
        chk("post_rst_vga_busy", vga_busy, 0);
        chk("post_rst_cpu_busy", cpu_busy, 0);
        step();
        chk("post_rst_mem_en", mem_en, 0);
        $display("txn reset done");

        // ---------------- single VGA read, minimum latency
        vga_req = 1'b1; vga_word_addr = 32'h10; vga_byte_sel = 4'hF;
        step();
        vga_req = 1'b0;
        chk("v1_busy_cap", vga_busy, 1);
        chk("v1_en_cap", mem_en, 0);
        step();
        chk("v1_en", mem_en, 1);
        chk("v1_addr", mem_addr, 32'h10);
        chk("v1_we", mem_we, 0);
        chk("v1_bs", mem_byte_sel, 4'hF);
        vga_req = 1'b1; vga_word_addr = 32'h11;   // request at the completing edge
        ack_with(32'hA5A5_00FF);
        vga_req = 1'b0;
        chk("v1_rdata", vga_rdata, 32'hA5A5_00FF);
        chk("v1_busy_done", vga_busy, 0);
        chk("v1_en_done", mem_en, 0);
        step();
        chk("v1_no_recapture", vga_busy, 0);
        chk("v1_no_access", mem_en, 0);
        $display("txn vga read 0x10 done");

        // ---------------- contention, active display: VGA first
        vga_state = 1'b1;
        vga_req = 1'b1; vga_word_addr = 32'h30;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        step();
        vga_req = 1'b0; cpu_req = 1'b0;
        chk("c1_vbusy", vga_busy, 1);
        chk("c1_cbusy", cpu_busy, 1);
        step();
        chk("c1_first_addr", mem_addr, 32'h30);
        chk("c1_cbusy_wait", cpu_busy, 1);
        ack_with(32'h1111_AAAA);
        chk("c1_vrdata", vga_rdata, 32'h1111_AAAA);
        chk("c1_vbusy_done", vga_busy, 0);
        chk("c1_cbusy_mid", cpu_busy, 1);
        step();
        chk("c1_second_en", mem_en, 1);
        chk("c1_second_addr", mem_addr, 32'h40);
        ack_with(32'h2222_BBBB);
        chk("c1_crdata", cpu_rdata, 32'h2222_BBBB);
        chk("c1_cbusy_done", cpu_busy, 0);
        $display("txn contention vga_state=1 done");

        // ---------------- contention, blanking, last grant VGA: CPU first
        vga_state = 1'b0;
        vga_req = 1'b1; vga_word_addr = 32'h50;
        step();
        vga_req = 1'b0;
        step();
        chk("c2_pre_addr", mem_addr, 32'h50);
        ack_with(32'h5050_5050);
        vga_req = 1'b1; vga_word_addr = 32'h70;
        cpu_req = 1'b1; cpu_addr = 32'h60;
        step();
        vga_req = 1'b0; cpu_req = 1'b0;
        step();
        chk("c2_first_addr", mem_addr, 32'h60);
        ack_with(32'h6060_DDDD);
        chk("c2_crdata", cpu_rdata, 32'h6060_DDDD);
        chk("c2_vbusy_mid", vga_busy, 1);
        step();
        chk("c2_second_addr", mem_addr, 32'h70);
        ack_with(32'h7070_CCCC);
        chk("c2_vrdata", vga_rdata, 32'h7070_CCCC);
        $display("txn contention vga_state=0 done");

        // ---------------- CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20;
        cpu_wdata = 32'h1234_5678; cpu_byte_sel = 4'b0011;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        chk("w_en", mem_en, 1);
        chk("w_we", mem_we, 1);
        chk("w_addr", mem_addr, 32'h20);
        chk("w_wdata", mem_wdata, 32'h1234_5678);
        chk("w_bs", mem_byte_sel, 4'b0011);
        ack_with(32'hDEAD_BEEF);
        chk("w_rdata_kept", cpu_rdata, 32'h6060_DDDD);
        chk("w_busy_done", cpu_busy, 0);
        chk("w_en_done", mem_en, 0);
        cpu_byte_sel = 4'hF;
        $display("txn cpu write 0x20 done");

        // ---------------- timeout on VGA, CPU pending behind it
        vga_state = 1'b1;
        vga_req = 1'b1; vga_word_addr = 32'h80;
        cpu_req = 1'b1; cpu_addr = 32'h90;
        step();
        vga_req = 1'b0; cpu_req = 1'b0;
        step();
        chk("to_en", mem_en, 1);
        chk("to_addr", mem_addr, 32'h80);
        n_hi = 1;
        for (int i = 0; i < 4 * TO; i++) begin
            step();
            if (mem_en !== 1'b1) break;
            n_hi++;
        end
        chk("to_len", n_hi, TO);
        chk("to_err", timeout_err, 1);
        chk("to_vrdata", vga_rdata, 0);
        chk("to_vbusy", vga_busy, 0);
        chk("to_cbusy", cpu_busy, 1);
        step();
        chk("to_err_pulse", timeout_err, 0);
        chk("to_next_en", mem_en, 1);
        chk("to_next_addr", mem_addr, 32'h90);
        ack_with(32'h9090_9090);
        chk("to_next_rdata", cpu_rdata, 32'h9090_9090);
        $display("txn timeout done");

        // ---------------- reset in the middle of an access
        vga_req = 1'b1; vga_word_addr = 32'hA0;
        cpu_req = 1'b1; cpu_addr = 32'hB0;
        step();
        vga_req = 1'b0; cpu_req = 1'b0;
        step(); step(); step();
        chk("mr_en_before", mem_en, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_en", mem_en, 0);
        chk("mr_vbusy", vga_busy, 0);
        chk("mr_cbusy", cpu_busy, 0);
        ack_with(32'h0000_0BAD);
        chk("mr_vrdata", vga_rdata, 0);
        chk("mr_crdata", cpu_rdata, 0);
        chk("mr_en_late", mem_en, 0);
        step();
        chk("mr_idle", mem_en, 0);
        $display("txn reset mid-access done");

        // ---------------- random phase against the model
        rst = 1'b1; vga_state = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = '{v: 1'b0, addr: 32'h0, bs: 4'h0, we: 1'b0, wd: 32'h0};
            rd[i]   = 32'h0;
        end
        for (int i = 0; i < 16; i++) sram[i] = $urandom;
        act = 1'b0; who = 0; age = 0; terr = 1'b0;
        last = 1;   // VGA preferred on the first tie

        for (int c = 0; c < 800; c++) begin
            stall         = (c % 200) >= 150;
            vga_req       = ($urandom_range(0, 2) == 0);
            vga_word_addr = 32'($urandom_range(0, 15));
            vga_byte_sel  = 4'($urandom);
            cpu_req       = ($urandom_range(0, 2) == 0);
            cpu_we        = 1'($urandom_range(0, 1));
            cpu_addr      = 32'($urandom_range(0, 15));
            cpu_wdata     = $urandom;
            cpu_byte_sel  = 4'($urandom);
            if ($urandom_range(0, 7) == 0) vga_state = ~vga_state;
            mem_rdata = $urandom;
            if (mem_en === 1'b1) begin
                mem_ack = !stall && ($urandom_range(0, 2) == 0);
                if (mem_ack) mem_rdata = sram[mem_addr[3:0]];
            end else begin
                mem_ack = ($urandom_range(0, 9) == 0);
            end

            // model: what the arbiter must look like after this edge
            cap_v = vga_req && !pend[0].v;
            cap_c = cpu_req && !pend[1].v;
            terr  = 1'b0;
            done  = -1;
            if (act) begin
                if (mem_ack) begin
                    if (pend[who].we) sram[pend[who].addr[3:0]] = pend[who].wd;
                    else rd[who] = mem_rdata;
                    pend[who].v = 1'b0; act = 1'b0; done = who;
                end else if (age == TO - 1) begin
                    rd[who] = 32'h0; pend[who].v = 1'b0; act = 1'b0;
                    terr = 1'b1; done = who;
                end else begin
                    age++;
                end
            end else if (pend[0].v || pend[1].v) begin
                if (pend[0].v && pend[1].v) who = vga_state ? 0 : 1 - last;
                else who = pend[0].v ? 0 : 1;
                last = who; act = 1'b1; age = 0;
            end
            if (cap_v) pend[0] = '{v: 1'b1, addr: vga_word_addr, bs: vga_byte_sel, we: 1'b0, wd: 32'h0};
            if (cap_c) pend[1] = '{v: 1'b1, addr: cpu_addr, bs: cpu_byte_sel, we: cpu_we, wd: cpu_wdata};

            step();
            mem_ack = 1'b0;

            chk("r_mem_en", mem_en, act);
            if (act) begin
                chk("r_mem_addr", mem_addr, pend[who].addr);
                chk("r_mem_bs", mem_byte_sel, pend[who].bs);
                chk("r_mem_we", mem_we, pend[who].we);
                if (who == 1) chk("r_mem_wdata", mem_wdata, pend[1].wd);
            end
            chk("r_vga_busy", vga_busy, pend[0].v);
            chk("r_cpu_busy", cpu_busy, pend[1].v);
            chk("r_vga_rdata", vga_rdata, rd[0]);
            chk("r_cpu_rdata", cpu_rdata, rd[1]);
            chk("r_terr", timeout_err, terr);
            if (done >= 0)
                $display("txn cycle %0d client=%s aborted=%0d rdata=%h",
                         c, (done == 0) ? "vga" : "cpu", terr, rd[done]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Sits directly upstream of the VGA output stage, between the shared SRAM and its two clients: the VGA pixel reader and the CPU data port.
- Captures one outstanding request per client and arbitrates between them. VGA has priority during active display; otherwise the two clients alternate round-robin.
- Runs one SRAM access at a time, with a wait-for-ack handshake and a timeout.
- Returns read data and a per-client busy flag. The VGA port's busy and data outputs drive the VGA stage's SRAM_busy and SRAM_data_in directly.

Parameters:
- ADDR_W, 32, word address width
- DATA_W, 32, SRAM word width
- TIMEOUT, 16, max cycles in ACCESS before the access is aborted (must be ≥2)

Ports:
- clk  in  1  system clock (25 MHz pixel domain)
- rst  in  1  reset, synchronous, active-high
- vga_req  in  1  VGA read request pulse
- vga_word_addr  in  ADDR_W  VGA read address
- vga_byte_sel  in  4  VGA byte lanes
- vga_state  in  1  1 = VGA in active display region
- vga_rdata  out  DATA_W  VGA read data
- vga_busy  out  1  VGA request pending or in service
- cpu_req  in  1  CPU request pulse
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_byte_sel  in  4  CPU byte lanes
- cpu_rdata  out  DATA_W  CPU read data
- cpu_busy  out  1  CPU request pending or in service
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_byte_sel  out  4  SRAM byte lanes
- mem_rdata  in  DATA_W  SRAM read data
- mem_ack  in  1  SRAM access complete (read data valid this cycle)
- timeout_err  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Reset: rst sampled high at a posedge sets the following.
  - State = IDLE.
  - All outputs = 0, including rdata registers, busy flags, all mem_* outputs and timeout_err.
  - Both request slots are emptied.
  - Round-robin pointer points to VGA.
- Reset mid-access: mem_en drops at that edge; any mem_ack arriving afterwards is ignored.
- Request capture, per client:
  - A req sampled high while that client's busy=0 latches address, byte_sel, and (CPU only) we and wdata into the client's slot.
  - busy goes high at that same edge.
  - req while busy=1 is ignored.
- State machine:
  - IDLE: choose a grant if any slot is full.
    - Both slots full and vga_state=1: VGA wins.
    - Both full and vga_state=0: the client not granted last wins.
    - Only one full: that client wins.
    - On grant: load mem_* from the slot, mem_en=1, timeout counter=0, go to ACCESS.
  - ACCESS: mem_en held high and mem_* held stable.
    - mem_ack=1: mem_en=0. For a read, the granted client's rdata <= mem_rdata. The granted busy clears and the slot empties at the same edge. Go to IDLE.
    - mem_ack=0: counter increments.
    - Counter reaches TIMEOUT-1 with no ack: abort. mem_en=0, granted rdata <= 0, busy clears, timeout_err pulses for 1 cycle, go to IDLE.
- Latency:
  - Idle arbiter, request captured at edge N: mem_en high at edge N+1.
  - Ack during the cycle after edge N+1: data and busy=0 visible after edge N+2.
  - Minimum turnaround is therefore 2 cycles from capture to data.
- Writes: the CPU write completes on mem_ack with cpu_rdata unchanged.
- Request during completion: a new req at the edge where busy clears is not captured, because busy was still 1 when sampled. The client must re-request on a later cycle.
- rdata outputs hold their last value until the next completion or abort for that client.
- mem_ack in IDLE is ignored.

Decomposition:
- Package vga_sram_pkg:
  - arb_state_t enum {IDLE, ACCESS}
  - grant_t enum {GNT_VGA, GNT_CPU}
  - req_t struct {addr, byte_sel, we, wdata}
  - default TIMEOUT constant
- Sub-module req_slot: one-entry request register with capture/clear and a full flag. Instantiated once per client.

Test Plan:
- Reset: hold rst high 2 cycles with both reqs high → all outputs 0, no mem_en. Release → both requests are captured only on a subsequent req pulse.
- Single VGA read: vga_req at addr 0x10, SRAM acks 1 cycle after mem_en with 0xA5A5_00FF → mem_addr=0x10. vga_rdata=0xA5A5_00FF and vga_busy=0 exactly 2 cycles after capture.
- Contention, vga_state=1: both reqs at the same edge → VGA served first, CPU served second with cpu_busy high throughout. Repeat with vga_state=0 and last grant VGA → CPU served first.
- CPU write: cpu_we=1, addr 0x20, wdata 0x1234_5678, byte_sel 4'b0011 → mem_we=1 and mem_* match exactly. cpu_rdata unchanged after the ack.
- Timeout: mem_ack never asserted → mem_en high for exactly TIMEOUT cycles, then timeout_err single pulse, granted rdata=0, busy=0, arbiter returns to IDLE and serves the next pending request.
- Reset mid-ACCESS: rst pulse 3 cycles into an access, then a late mem_ack → mem_en low after the reset edge, no rdata update, both busy flags 0.
